ysyx_22050243_mdu: RTL and testbench

Iterative multiply/divide unit for the RV64 EX stage. It covers the M-extension operations, plus the RV64 word forms when configured. The execution path already decodes integer ALU ops. This block takes M-type ops from that same decode path through a valid/ready handshake and returns one result per accepted op after a data-dependent, multi-cycle latency. Datapath width is parametrised: radix-2 shift-add multiply and restoring divide, with a single-cycle fast path for division special cases.

---
 rtl/ysyx_22050243_mdu_pkg.sv | 30 +++
 rtl/ysyx_22050243_mdu_opprep.sv | 79 +++++++
 rtl/ysyx_22050243_mdu.sv | 194 +++++++++++++++++++
 tb/tb_ysyx_22050243_mdu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050243_mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: funct3 op codes, FSM states,
// and the counter-width helper.
package ysyx_22050243_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;
  localparam int unsigned MDU_WORD_BIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ysyx_22050243_mdu_opprep.sv
// Operand preparation: W extension (YSYX_22050243_MDU_WORD_OPS_EN), signedness, magnitudes,
// result sign and single-cycle division special cases. Purely combinational.
module ysyx_22050243_mdu_opprep
  import ysyx_22050243_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_word,
  output logic [XLEN-1:0] o_mag1,
  output logic [XLEN-1:0] o_mag2,
  output logic            o_neg,
  output logic            o_spc,
  output logic [XLEN-1:0] o_spc_res
);

  logic [2:0]      w_f3;
  logic            w_div;
  logic            w_rem;
  logic            w_s1;
  logic            w_s2;
  logic [XLEN-1:0] w_ext1;
  logic [XLEN-1:0] w_ext2;
  logic [XLEN-1:0] w_min;
  logic            w_neg1;
  logic            w_neg2;
  logic            w_zero;
  logic            w_ovf;

  assign w_f3  = i_op[2:0];
  assign w_div = w_f3[2];
  assign w_rem = w_f3[2] & w_f3[1];
  assign w_s1  = (w_f3 == MDU_MULH) | (w_f3 == MDU_MULHSU) | (w_f3 == MDU_DIV) | (w_f3 == MDU_REM);
  assign w_s2  = (w_f3 == MDU_MULH) | (w_f3 == MDU_DIV) | (w_f3 == MDU_REM);

`ifdef YSYX_22050243_MDU_WORD_OPS_EN
  assign o_word = i_op[MDU_WORD_BIT];
  always_comb begin
    w_ext1 = i_src1;
    w_ext2 = i_src2;
    if (o_word) begin
      w_ext1 = {{(XLEN-32){w_s1 & i_src1[31]}}, i_src1[31:0]};
      w_ext2 = {{(XLEN-32){w_s2 & i_src2[31]}}, i_src2[31:0]};
    end
  end
  // Most-negative value of the active width, seen after sign extension.
  assign w_min = o_word ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
`else
  logic w_unused_word;
  assign w_unused_word = i_op[MDU_WORD_BIT];
  assign o_word = 1'b0;
  assign w_ext1 = i_src1;
  assign w_ext2 = i_src2;
  assign w_min  = {1'b1, {(XLEN-1){1'b0}}};
`endif

  assign w_neg1 = w_s1 & w_ext1[XLEN-1];
  assign w_neg2 = w_s2 & w_ext2[XLEN-1];
  assign o_mag1 = w_neg1 ? -w_ext1 : w_ext1;
  assign o_mag2 = w_neg2 ? -w_ext2 : w_ext2;
  // Remainder takes the dividend's sign; products and quotients take the XOR.
  assign o_neg  = w_rem ? w_neg1 : (w_neg1 ^ w_neg2);

  assign w_zero = (w_ext2 == '0);
  assign w_ovf  = w_s1 & w_div & (w_ext1 == w_min) & (&w_ext2);
  assign o_spc  = w_div & (w_zero | w_ovf);

  always_comb begin
    o_spc_res = '0;
    if (w_zero) begin
      o_spc_res = w_rem ? w_ext1 : '1;
    end else if (w_ovf) begin
      o_spc_res = w_rem ? '0 : w_ext1;
    end
  end

endmodule

// File: rtl/ysyx_22050243_mdu.sv
// Iterative RV64 M-extension unit: radix-2 shift-add multiply / restoring divide, N = XLEN (32 for
// W forms under YSYX_22050243_MDU_WORD_OPS_EN) cycles, specials in 1; result held until out_ready.
module ysyx_22050243_mdu
  import ysyx_22050243_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = clog2(XLEN);

  mdu_state_e        r_state;
  mdu_state_e        w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic              r_neg;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_acc_init;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rmd;
  logic [XLEN-1:0]   w_fin;
  logic [XLEN-1:0]   w_pre;
  logic [XLEN-1:0]   w_res;
  logic              w_accept;
  logic              w_word_in;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_neg_in;
  logic              w_spc;
  logic [XLEN-1:0]   w_spc_res;
`ifdef YSYX_22050243_MDU_WORD_OPS_EN
  logic              r_word;
`endif

  ysyx_22050243_mdu_opprep #(.XLEN(XLEN)) u_opprep (
    .i_op      (i_op),
    .i_src1    (i_src1),
    .i_src2    (i_src2),
    .o_word    (w_word_in),
    .o_mag1    (w_mag1),
    .o_mag2    (w_mag2),
    .o_neg     (w_neg_in),
    .o_spc     (w_spc),
    .o_spc_res (w_spc_res)
  );

  assign w_accept = i_in_valid & (r_state == IDLE) & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        if (w_accept) begin
          w_state_nxt = w_spc ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = IDLE;
    end
  end

  // One step: multiply shifts {hi,lo} right adding the multiplicand; divide shifts {rem,quo} left.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
    w_diff    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
    w_acc_nxt = r_acc;
    if (r_f3[2]) begin
      if (!w_diff[XLEN]) begin
        w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = {r_acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      if (r_acc[0]) begin
        w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
      end else begin
        w_acc_nxt = {1'b0, r_acc[2*XLEN-1:1]};
      end
    end
  end

  always_comb begin
    w_acc_init = {{XLEN{1'b0}}, w_mag1};
`ifdef YSYX_22050243_MDU_WORD_OPS_EN
    // A 32-step divide must see the dividend in the top half of the quotient register.
    if (w_word_in & i_op[2]) begin
      w_acc_init = {{XLEN{1'b0}}, w_mag1 << 32};
    end
`endif
  end

  always_comb begin
    w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_quo  = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    w_rmd  = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    if (r_f3[2]) begin
      w_fin = r_f3[1] ? w_rmd : w_quo;
    end else if (r_f3[1:0] == 2'b00) begin
      w_fin = w_prod[XLEN-1:0];
    end else begin
      w_fin = w_prod[2*XLEN-1:XLEN];
    end
`ifdef YSYX_22050243_MDU_WORD_OPS_EN
    // After 32 multiply steps the product sits one word up in the register.
    if (r_word & ~r_f3[2]) begin
      w_fin = {{(XLEN-32){1'b0}}, w_prod[63:32]};
    end
`endif
  end

  always_comb begin
    w_pre = (r_state == IDLE) ? w_spc_res : w_fin;
    w_res = w_pre;
`ifdef YSYX_22050243_MDU_WORD_OPS_EN
    if ((r_state == IDLE) ? w_word_in : r_word) begin
      w_res = {{(XLEN-32){w_pre[31]}}, w_pre[31:0]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      o_result <= '0;
`ifdef YSYX_22050243_MDU_WORD_OPS_EN
      r_word   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_f3  <= i_op[2:0];
      r_neg <= w_neg_in;
      r_b   <= w_mag2;
      r_acc <= w_acc_init;
      r_cnt <= w_word_in ? CW'(31) : CW'(XLEN-1);
`ifdef YSYX_22050243_MDU_WORD_OPS_EN
      r_word <= w_word_in;
`endif
      if (w_spc) begin
        o_result <= w_res;
      end
    end else if ((r_state == CALC) && !i_flush) begin
      r_acc <= w_acc_nxt;
      if (r_cnt == '0) begin
        o_result <= w_res;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_mdu.sv
// Randomized and directed bench for ysyx_22050243_mdu against an arithmetic reference model.
module tb_ysyx_22050243_mdu;

`ifdef YSYX_22050243_MDU_WORD_OPS_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [3:0]  i_op;
  logic [63:0] i_src1;
  logic [63:0] i_src2;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [63:0] o_result;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22050243_mdu #(.XLEN(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_op        (i_op),
    .i_src1      (i_src1),
    .i_src2      (i_src2),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: what an RV64 M-extension op returns, and after how many cycles.
  function automatic void ref_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] res, output int lat);
    logic              word;
    logic              zero;
    logic              ovf;
    logic [127:0]      p;
    logic signed [63:0] sq;
    logic signed [31:0] wq;
    logic [31:0]       a32;
    logic [31:0]       b32;
    logic [31:0]       r32;
    word = WORD_EN && op[3];
    lat  = word ? 33 : 65;
    res  = '0;
    if (word) begin
      a32  = a[31:0];
      b32  = b[31:0];
      zero = (b32 == 32'd0);
      ovf  = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
      r32  = a32 * b32;
      case (op[2:0])
        3'd4: if (zero) r32 = '1; else if (ovf) r32 = a32; else begin wq = $signed(a32) / $signed(b32); r32 = wq; end
        3'd5: if (zero) r32 = '1; else r32 = a32 / b32;
        3'd6: if (zero) r32 = a32; else if (ovf) r32 = '0; else begin wq = $signed(a32) % $signed(b32); r32 = wq; end
        3'd7: if (zero) r32 = a32; else r32 = a32 % b32;
        default: ;
      endcase
      res = {{32{r32[31]}}, r32};
    end else begin
      zero = (b == 64'd0);
      ovf  = (a == 64'h8000_0000_0000_0000) && (b == '1);
      p    = {64'd0, a} * {64'd0, b};
      case (op[2:0])
        3'd0: res = p[63:0];
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; res = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; res = p[127:64]; end
        3'd3: res = p[127:64];
        3'd4: if (zero) res = '1; else if (ovf) res = a; else begin sq = $signed(a) / $signed(b); res = sq; end
        3'd5: if (zero) res = '1; else res = a / b;
        3'd6: if (zero) res = a; else if (ovf) res = '0; else begin sq = $signed(a) % $signed(b); res = sq; end
        default: if (zero) res = a; else res = a % b;
      endcase
    end
    if (op[2] && (zero || (ovf && !op[0]))) lat = 1;
  endfunction

  // Model state: an op is outstanding from accept until its result handshake or a flush.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_due = 0;
  logic [63:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    int lat;
    if (!rst_n) begin
      m_busy = 1'b0;
    end else begin
      if (i_flush) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (i_in_valid) begin
          ref_op(i_op, i_src1, i_src2, m_res, lat);
          m_busy = 1'b1;
          m_due  = cyc + lat;
        end
      end else if (cyc >= m_due && i_out_ready) begin
        m_busy = 1'b0;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {63'd0, o_in_ready}, {63'd0, !m_busy});
      chk("out_valid", {63'd0, o_out_valid}, {63'd0, (m_busy && cyc >= m_due)});
      if (m_busy && cyc >= m_due) chk("result", o_result, m_res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int guard = 0;
    while (!o_in_ready && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_wait: got in_ready=0 for %0d cycles required in_ready=1", guard);
    end
    i_in_valid = 1'b1;
    i_op       = op;
    i_src1     = a;
    i_src2     = b;
    step();
    i_in_valid = 1'b0;
    i_src1     = {$urandom, $urandom};
    i_src2     = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic do_dir(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    chk(name, o_result, exp_res);
    chk({name, "_lat"}, lat, exp_lat);
    step();
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return 64'h0000_0000_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int lat;
    logic [3:0] rop;
    rst_n       = 1'b0;
    i_flush     = 1'b0;
    i_in_valid  = 1'b0;
    i_op        = '0;
    i_src1      = '0;
    i_src2      = '0;
    i_out_ready = 1'b1;
    #1;
    chk("reset_in_ready", {63'd0, o_in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, o_out_valid}, 64'd0);
    chk("reset_result", o_result, 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    do_dir("mul_3_m5", 4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    do_dir("mulhu_m1", 4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    do_dir("mulh_m1", 4'd1, '1, '1, 64'd0, 65);
    do_dir("div_by0", 4'd4, 64'd7, 64'd0, '1, 1);
    do_dir("rem_by0", 4'd6, 64'd7, 64'd0, 64'd7, 1);
    do_dir("div_ovf", 4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    do_dir("rem_ovf", 4'd6, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    do_dir("divw", 4'd12, 64'h0000_0000_8000_0000, 64'd1,
           WORD_EN ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000, WORD_EN ? 33 : 65);
    do_dir("remw", 4'd14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, WORD_EN ? 33 : 65);

    issue(4'd5, 64'd100, 64'd7);
    repeat (9) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_in_ready", {63'd0, o_in_ready}, 64'd1);
    chk("flush_out_valid", {63'd0, o_out_valid}, 64'd0);
    do_dir("remu_after_flush", 4'd7, 64'd100, 64'd7, 64'd2, 65);

    i_out_ready = 1'b0;
    issue(4'd5, 64'd100, 64'd7);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      chk("hold_result", o_result, 64'd14);
      chk("hold_in_ready", {63'd0, o_in_ready}, 64'd0);
      step();
    end
    i_out_ready = 1'b1;
    step();

    issue(4'd0, 64'd12345, 64'd678);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", {63'd0, o_in_ready}, 64'd1);
    chk("midreset_out_valid", {63'd0, o_out_valid}, 64'd0);
    chk("midreset_result", o_result, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    do_dir("div_after_reset", 4'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);

    for (int k = 0; k < 4000; k++) begin
      rop = 4'($urandom_range(0, 15));
      if (rop[3] && rop[2:0] != 3'd0 && !rop[2]) rop[2:0] = 3'd0;
      i_op        = rop;
      i_src1      = pick();
      i_src2      = pick();
      i_in_valid  = ($urandom_range(0, 3) != 0);
      i_out_ready = ($urandom_range(0, 3) != 0);
      i_flush     = ($urandom_range(0, 127) == 0);
      step();
    end
    i_in_valid  = 1'b0;
    i_flush     = 1'b0;
    i_out_ready = 1'b1;
    repeat (100) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
